// File: rtl/gearbox_ctrl_param.sv
// Parametrised automatic-transmission controller: P/R/N/D selector gating,
// hysteretic auto shifts, kickdown, manual override and post-shift dwell.
module gearbox_ctrl_param #(
    parameter int NUM_GEARS = 6,
    parameter int SPEED_W   = 8,
    parameter int GEAR_W    = 4,
    parameter int STEP      = 40,
    parameter int HYST      = 8,
    parameter int DWELL     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SPEED_W-1:0] speed,
    input  logic [1:0]         sel,
    input  logic               brake,
    input  logic               kick,
    input  logic               man_en,
    input  logic               man_up,
    input  logic               man_dn,
    output logic [1:0]         mode,
    output logic [GEAR_W-1:0]  gear,
    output logic               shifting,
    output logic               reject
);
    localparam int AW = SPEED_W + GEAR_W + 1;
    localparam int CW = $clog2(DWELL + 1);
    localparam logic [AW-1:0]     STEP_A = AW'(STEP);
    localparam logic [AW-1:0]     HYST_A = AW'(HYST);
    localparam logic [GEAR_W-1:0] G_ONE  = GEAR_W'(1);
    localparam logic [GEAR_W-1:0] G_TOP  = GEAR_W'(NUM_GEARS);
    localparam logic [CW-1:0]     DW_LD  = CW'(DWELL);

    typedef enum logic [1:0] {
        M_P = 2'd0,
        M_R = 2'd1,
        M_N = 2'd2,
        M_D = 2'd3
    } mode_e;

    mode_e             mode_q, mode_d;
    logic [GEAR_W-1:0] gear_q, gear_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              reject_q, reject_d;

    logic [AW-1:0] spd_a, up_cur, up_low, dn_cur;
    logic          accept, can_dn, can_up;

    function automatic logic [AW-1:0] up_th(input logic [GEAR_W-1:0] g);
        return AW'(g) * STEP_A + HYST_A;
    endfunction

    function automatic logic [AW-1:0] dn_th(input logic [GEAR_W-1:0] g);
        return AW'(g - G_ONE) * STEP_A;
    endfunction

    always_comb begin
        spd_a    = AW'(speed);
        up_cur   = up_th(gear_q);
        up_low   = up_th(gear_q - G_ONE);
        dn_cur   = dn_th(gear_q);
        can_dn   = gear_q > G_ONE;
        can_up   = gear_q < G_TOP;
        accept   = 1'b0;
        mode_d   = mode_q;
        gear_d   = gear_q;
        reject_d = 1'b0;
        cnt_d    = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;

        if (sel != mode_q) begin
            unique case (sel)
                2'd0, 2'd1: accept = (speed == '0) && brake;
                2'd2:       accept = 1'b1;
                default:    accept = (mode_q == M_N) || brake;
            endcase
            if (accept) begin
                mode_d = mode_e'(sel);
                gear_d = (sel == 2'd3) ? G_ONE : '0;
                cnt_d  = '0;
            end else begin
                reject_d = 1'b1;
            end
        end

        // Gear decisions only while staying in D with the lockout expired.
        if (!accept && mode_q == M_D && cnt_q == '0) begin
            if (kick && can_dn && spd_a < up_low) begin
                gear_d = gear_q - G_ONE;
            end else if (can_dn && spd_a < dn_cur) begin
                gear_d = gear_q - G_ONE;
            end else if (man_en) begin
                if (man_up && can_up) begin
                    gear_d = gear_q + G_ONE;
                end else if (man_dn && can_dn) begin
                    gear_d = gear_q - G_ONE;
                end
            end else if (can_up && spd_a >= up_cur) begin
                gear_d = gear_q + G_ONE;
            end
            if (gear_d != gear_q) begin
                cnt_d = DW_LD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= M_P;
            gear_q   <= '0;
            cnt_q    <= '0;
            reject_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            gear_q   <= gear_d;
            cnt_q    <= cnt_d;
            reject_q <= reject_d;
        end
    end

    assign mode     = mode_q;
    assign gear     = gear_q;
    assign shifting = (cnt_q != '0);
    assign reject   = reject_q;
endmodule
